// File: rtl/adc_capture_bram_ctrl.sv
// ADC capture sequencer and single-port BRAM arbiter shared with the SCARF SPI slave.
// Optional decimation in CAPTURE is enabled with `define CAP_DECIM_EN (adds the decim port).
module adc_capture_bram_ctrl #(
    parameter int unsigned NUM_SAMPLES = 32'h1000,
    parameter logic [15:0] BASE_ADDR   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n_sync,
    input  logic        cap_start,
    input  logic        cap_abort,
    input  logic        trig_mode,
    input  logic [7:0]  trig_level,
    input  logic [7:0]  adc_data,
    input  logic        adc_valid,
    input  logic [15:0] spi_bram_addr,
    input  logic [7:0]  spi_bram_wdata,
    input  logic        spi_bram_wen,
    input  logic        spi_bram_ren,
`ifdef CAP_DECIM_EN
    input  logic [3:0]  decim,
`endif
    output logic [15:0] bram_addr,
    output logic [7:0]  bram_wdata,
    output logic        bram_wen,
    output logic        bram_ren,
    output logic        cap_busy,
    output logic        cap_done,
    output logic        spi_conflict,
    output logic [15:0] cap_count
);

    localparam logic [16:0] LAST_COUNT = 17'(NUM_SAMPLES - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [16:0] r_capCount;
    logic [7:0]  r_prevSample;
    logic        r_capWen;
    logic [15:0] r_capAddr;
    logic [7:0]  r_capWdata;
    logic        r_spiConflict;

    logic w_busy;
    logic w_armEntry;
    logic w_trigger;
    logic w_decimHit;
    logic w_accept;
    logic w_lastSample;
    logic w_capOwn;

    assign w_busy       = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign w_armEntry   = cap_start && !cap_abort && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_trigger    = trig_mode ? ((r_prevSample < trig_level) && (adc_data >= trig_level)) : 1'b1;
    assign w_lastSample = (r_capCount == LAST_COUNT);

`ifdef CAP_DECIM_EN
    logic [3:0] r_decimCnt;
    logic [3:0] r_decimVal;

    assign w_decimHit = (r_decimCnt == r_decimVal);

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_decimCnt <= 4'd0;
            r_decimVal <= 4'd0;
        end else if (r_state == S_ARMED && w_accept) begin
            r_decimCnt <= 4'd0;
            r_decimVal <= decim;
        end else if (r_state == S_CAPTURE && adc_valid && !cap_abort) begin
            r_decimCnt <= w_decimHit ? 4'd0 : r_decimCnt + 4'd1;
        end
    end
`else
    assign w_decimHit = 1'b1;
`endif

    // A sample is taken on the trigger in ARMED or on a decimation hit in CAPTURE; abort always wins.
    assign w_accept = adc_valid && !cap_abort &&
                      (((r_state == S_ARMED) && w_trigger) || ((r_state == S_CAPTURE) && w_decimHit));

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_state <= S_IDLE;
        end else if (cap_abort) begin
            r_state <= S_IDLE;
        end else if (w_armEntry) begin
            r_state <= S_ARMED;
        end else if (w_accept) begin
            r_state <= w_lastSample ? S_DONE : S_CAPTURE;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_capWen   <= 1'b0;
            r_capAddr  <= 16'h0000;
            r_capWdata <= 8'h00;
        end else begin
            r_capWen <= w_accept;
            if (w_accept) begin
                r_capAddr  <= BASE_ADDR + r_capCount[15:0];
                r_capWdata <= adc_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_capCount <= 17'd0;
        end else if (w_armEntry) begin
            r_capCount <= 17'd0;
        end else if (w_accept) begin
            r_capCount <= r_capCount + 17'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_prevSample <= 8'hFF;
        end else if (w_armEntry) begin
            r_prevSample <= 8'hFF;
        end else if (r_state == S_ARMED && adc_valid && !cap_abort) begin
            r_prevSample <= adc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_spiConflict <= 1'b0;
        end else if (w_armEntry) begin
            r_spiConflict <= 1'b0;
        end else if (w_busy && (spi_bram_wen || spi_bram_ren)) begin
            r_spiConflict <= 1'b1;
        end
    end

    // The capture side keeps the port for its final write even after the FSM has left the busy states.
    assign w_capOwn   = w_busy || r_capWen;
    assign bram_addr  = w_capOwn ? r_capAddr  : spi_bram_addr;
    assign bram_wdata = w_capOwn ? r_capWdata : spi_bram_wdata;
    assign bram_wen   = w_capOwn ? r_capWen   : spi_bram_wen;
    assign bram_ren   = w_capOwn ? 1'b0       : spi_bram_ren;

    assign cap_busy     = w_busy;
    assign cap_done     = (r_state == S_DONE);
    assign spi_conflict = r_spiConflict;
    assign cap_count    = r_capCount[15:0];

endmodule

// File: tb/tb_adc_capture_bram_ctrl.sv
// Scoreboard bench for adc_capture_bram_ctrl: expected BRAM writes are queued by the stimulus
// and popped by an independent write monitor.
module tb_adc_capture_bram_ctrl;

    localparam int unsigned NUM      = 4;
    localparam logic [15:0] BASE     = 16'h0020;

    logic        clk = 1'b0;
    logic        rst_n_sync = 1'b0;
    logic        cap_start = 1'b0;
    logic        cap_abort = 1'b0;
    logic        trig_mode = 1'b0;
    logic [7:0]  trig_level = 8'h00;
    logic [7:0]  adc_data = 8'h00;
    logic        adc_valid = 1'b0;
    logic [15:0] spi_bram_addr = 16'h0000;
    logic [7:0]  spi_bram_wdata = 8'h00;
    logic        spi_bram_wen = 1'b0;
    logic        spi_bram_ren = 1'b0;
`ifdef CAP_DECIM_EN
    logic [3:0]  decim = 4'd0;
`endif
    logic [15:0] bram_addr;
    logic [7:0]  bram_wdata;
    logic        bram_wen;
    logic        bram_ren;
    logic        cap_busy;
    logic        cap_done;
    logic        spi_conflict;
    logic [15:0] cap_count;

    int          vecCount = 0;
    int          failCount = 0;
    logic [23:0] expQ[$];
    logic [7:0]  mem [0:65535];

    adc_capture_bram_ctrl #(.NUM_SAMPLES(NUM), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n_sync(rst_n_sync), .cap_start(cap_start), .cap_abort(cap_abort),
        .trig_mode(trig_mode), .trig_level(trig_level), .adc_data(adc_data), .adc_valid(adc_valid),
        .spi_bram_addr(spi_bram_addr), .spi_bram_wdata(spi_bram_wdata),
        .spi_bram_wen(spi_bram_wen), .spi_bram_ren(spi_bram_ren),
`ifdef CAP_DECIM_EN
        .decim(decim),
`endif
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_wen(bram_wen), .bram_ren(bram_ren),
        .cap_busy(cap_busy), .cap_done(cap_done), .spi_conflict(spi_conflict), .cap_count(cap_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vecCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic abort, input logic valid,
                                 input logic [7:0] data, input logic spiW, input logic spiR,
                                 input logic [15:0] sAddr, input logic [7:0] sData);
        cap_start      = start;
        cap_abort      = abort;
        adc_valid      = valid;
        adc_data       = data;
        spi_bram_wen   = spiW;
        spi_bram_ren   = spiR;
        spi_bram_addr  = sAddr;
        spi_bram_wdata = sData;
        @(posedge clk);
        #1;
        cap_start    = 1'b0;
        cap_abort    = 1'b0;
        adc_valid    = 1'b0;
        spi_bram_wen = 1'b0;
        spi_bram_ren = 1'b0;
    endtask

    task automatic sample(input logic [7:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic expectWrite(input logic [15:0] a, input logic [7:0] d);
        expQ.push_back({a, d});
    endtask

    // Write monitor: every BRAM write must match the oldest queued expectation.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (bram_wen === 1'b1) begin
                mem[bram_addr] = bram_wdata;
                if (expQ.size() == 0) begin
                    vecCount++;
                    failCount++;
                    $display("[TB] FAIL unexpectedWrite actual addr=%h data=%h required no write",
                             bram_addr, bram_wdata);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("writeAddr", 32'(bram_addr), 32'(e[23:8]));
                    checkOutput("writeData", 32'(bram_wdata), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // Reset values and IDLE pass-through
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", 32'(cap_busy), 0);
        checkOutput("rstDone", 32'(cap_done), 0);
        checkOutput("rstConflict", 32'(spi_conflict), 0);
        checkOutput("rstCount", 32'(cap_count), 0);
        checkOutput("rstWen", 32'(bram_wen), 0);
        rst_n_sync = 1'b1;
        spi_bram_addr = 16'h1234;
        spi_bram_ren = 1'b1;
        #1;
        checkOutput("idleAddrMux", 32'(bram_addr), 32'h1234);
        checkOutput("idleRenMux", 32'(bram_ren), 1);
        spi_bram_ren = 1'b0;
        spi_bram_addr = 16'h0000;

        // Immediate trigger, six samples offered, four stored
        $display("[TB] immediate-trigger capture");
        trig_mode = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("armBusy", 32'(cap_busy), 1);
        checkOutput("armCount", 32'(cap_count), 0);
        expectWrite(BASE + 16'd0, 8'd10);
        expectWrite(BASE + 16'd1, 8'd11);
        expectWrite(BASE + 16'd2, 8'd12);
        expectWrite(BASE + 16'd3, 8'd13);
        for (int i = 10; i <= 15; i++) sample(8'(i));
        checkOutput("t1Done", 32'(cap_done), 1);
        checkOutput("t1Busy", 32'(cap_busy), 0);
        checkOutput("t1Count", 32'(cap_count), 4);
        checkOutput("t1Mem3", 32'(mem[BASE + 16'd3]), 13);

        // Rising-crossing trigger at 0x80
        $display("[TB] level-crossing capture");
        trig_mode = 1'b1;
        trig_level = 8'h80;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("t2DoneClr", 32'(cap_done), 0);
        checkOutput("t2CountClr", 32'(cap_count), 0);
        expectWrite(BASE + 16'd0, 8'h80);
        expectWrite(BASE + 16'd1, 8'h90);
        expectWrite(BASE + 16'd2, 8'hA0);
        expectWrite(BASE + 16'd3, 8'hB0);
        sample(8'h70);
        sample(8'h7F);
        checkOutput("t2NoTrig", 32'(cap_count), 0);
        sample(8'h80);
        sample(8'h90);
        sample(8'hA0);
        sample(8'hB0);
        checkOutput("t2Done", 32'(cap_done), 1);
        checkOutput("t2Mem0", 32'(mem[BASE]), 32'h80);

        // Above-level first sample must not trigger until a dip and rise
        $display("[TB] no trigger from initial high level");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        sample(8'hC0);
        sample(8'hC0);
        checkOutput("t3NoTrig", 32'(cap_count), 0);
        checkOutput("t3StillArmed", 32'(cap_busy), 1);
        sample(8'h50);
        expectWrite(BASE, 8'h85);
        sample(8'h85);
        checkOutput("t3Trig", 32'(cap_count), 1);

        // SPI access while busy is dropped and flagged
        $display("[TB] SPI conflict and abort");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0010, 8'h5A);
        checkOutput("t4Conflict", 32'(spi_conflict), 1);
        checkOutput("t4MemUntouched", 32'(mem[16'h0010]), 0);
        spi_bram_ren = 1'b1;
        #1;
        checkOutput("t4RenBlocked", 32'(bram_ren), 0);
        spi_bram_ren = 1'b0;

        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("t5AbortBusy", 32'(cap_busy), 0);
        checkOutput("t5AbortDone", 32'(cap_done), 0);
        checkOutput("t5CountHeld", 32'(cap_count), 1);
        sample(8'h11);
        sample(8'h12);
        expectWrite(16'h0010, 8'h5A);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0010, 8'h5A);
        checkOutput("t4IdleWrite", 32'(mem[16'h0010]), 32'h5A);
        checkOutput("t5ConflictSticky", 32'(spi_conflict), 1);

        // Reset in the middle of a capture
        $display("[TB] reset mid-capture");
        trig_mode = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkOutput("t5ConflictCleared", 32'(spi_conflict), 0);
        expectWrite(BASE, 8'h44);
        sample(8'h44);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0100, 8'h00);
        checkOutput("t5ConflictRen", 32'(spi_conflict), 1);
        sample(8'h45);
        rst_n_sync = 1'b0;
        #1;
        checkOutput("t5RstBusy", 32'(cap_busy), 0);
        checkOutput("t5RstCount", 32'(cap_count), 0);
        checkOutput("t5RstConflict", 32'(spi_conflict), 0);
        checkOutput("t5RstWen", 32'(bram_wen), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n_sync = 1'b1;

`ifdef CAP_DECIM_EN
        $display("[TB] decimated capture");
        decim = 4'd2;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        expectWrite(BASE + 16'd0, 8'd0);
        expectWrite(BASE + 16'd1, 8'd3);
        expectWrite(BASE + 16'd2, 8'd6);
        for (int i = 0; i <= 8; i++) sample(8'(i));
        checkOutput("t6Count", 32'(cap_count), 3);
        checkOutput("t6Busy", 32'(cap_busy), 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("pendingWrites", 32'(expQ.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
